ledsweep: RTL
=============

LEDSWEEP -- requirements
Module: ledsweep

Interface
REQ-001 Parameter NLED, default 8, number of LEDs; legal range 2..32.
REQ-002 Parameter DIVW, default 16, width of the step-period register; legal range 1..32.
REQ-003 Parameter DEF_PERIOD, default 0, reset value of the step-period register.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined bus cycle, strobe, write enable.
REQ-007 i_wb_addr  in  1  register select: 0 = CTRL, 1 = PERIOD.
REQ-008 i_wb_data  in  32  write data.
REQ-009 o_wb_stall  out  1  request not accepted this cycle.
REQ-010 o_wb_ack  out  1  single-cycle acknowledge.
REQ-011 o_wb_data  out  32  read data, valid with o_wb_ack.
REQ-012 o_led  out  NLED  one-hot LED drive; all zero when idle.
REQ-013 o_busy  out  1  high while a sweep is in progress.
REQ-014 o_int  out  1  sweep-complete pulse; present only with LEDSWEEP_IRQ_EN.

Function
REQ-015 Accepted request = i_wb_cyc & i_wb_stb & !o_wb_stall.
REQ-016 o_wb_stall SHALL be o_busy & i_wb_we & (i_wb_addr==0); all other requests are never stalled.
REQ-017 o_wb_ack SHALL be 1 exactly one cycle after each accepted request, else 0; reads and writes both ack.
REQ-018 CTRL write: bits[7:0] = REPS (sweep runs REPS+1 passes); bit[8] = MODE (0 bounce, 1 one-way); other bits ignored.
REQ-019 PERIOD write: bits[DIVW-1:0] = P; each position is held P+1 cycles; a write while busy takes effect at the next position reload.
REQ-020 CTRL read: {o_busy, 14'b0, MODE, remaining passes minus one [7:0], 3'b0, position [4:0]}; PERIOD read: P zero-extended.
REQ-021 States: IDLE, RUN. IDLE->RUN on an accepted CTRL write; RUN->IDLE when the hold of the final position expires.
REQ-022 The cycle after an accepted CTRL write: o_busy=1, position 0, o_led bit0 = 1, hold counter loaded with P.
REQ-023 Bounce pass: positions 0,1..NLED-1,NLED-2..0; passes after the first omit the leading 0, so position 0 is never shown twice in a row.
REQ-024 One-way pass: positions 0..NLED-1; every pass starts at 0.
REQ-025 Total busy cycles: bounce ((REPS+1)(2*NLED-2)+1)(P+1); one-way (REPS+1)*NLED*(P+1).
REQ-026 On the RUN->IDLE edge, o_busy and o_led SHALL both become 0 in the same cycle.
REQ-027 The hold counter is DIVW bits wide and counts down to 0 with no wrap; P=0 means one cycle per position.
REQ-028 A CTRL read while busy returns live values without disturbing the sweep.

Reset
REQ-029 While i_reset_n=0: state IDLE, o_busy=0, o_led=0, o_wb_ack=0, o_int=0, P=DEF_PERIOD, REPS=0, MODE=0, position=0.
REQ-030 Reset asserted mid-sweep aborts the sweep immediately and asynchronously; after release the block is IDLE and the bus request must be reissued.

Configuration
REQ-031 With macro LEDSWEEP_IRQ_EN defined, port o_int exists and is 1 for exactly the one cycle in which o_busy falls.
REQ-032 Without LEDSWEEP_IRQ_EN, port o_int and its logic are absent and all other behaviour is identical.

Verification
REQ-033 NLED=8, P=0, write CTRL=0x000 -> o_led steps 01,02,04..80,40..01 one per cycle, o_busy high for 15 cycles, then o_led=0.
REQ-034 P=2, CTRL=0x100 -> each of 8 one-way positions held 3 cycles; busy for 24 cycles.
REQ-035 P=0, CTRL=0x002 -> busy for 3*14+1=43 cycles; 0x01 never appears on two consecutive cycles.
REQ-036 A second CTRL write during busy -> o_wb_stall=1 until o_busy falls; accepted on the following cycle, ack one cycle later, new sweep starts.
REQ-037 PERIOD write and CTRL read during busy -> no stall, ack the next cycle, read position matches o_led.
REQ-038 i_reset_n pulsed low mid-sweep -> o_led=0 and o_busy=0 immediately; with LEDSWEEP_IRQ_EN, o_int stays 0.

Source files
------------

// File: rtl/ledsweep_if.sv
// Wishbone pipelined register port of the ledsweep LED chaser.
// The master drives the request, and the slave returns stall, ack and read data.
interface ledsweep_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic        i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output o_wb_stall, o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/ledsweep.sv
// One-hot LED sweeper (bounce or one-way) with CTRL/PERIOD registers on a Wishbone port.
// Defining LEDSWEEP_IRQ_EN adds o_int, a one-cycle pulse when a sweep completes.
module ledsweep #(
   parameter int unsigned NLED       = 8,
   parameter int unsigned DIVW       = 16,
   parameter int unsigned DEF_PERIOD = 0
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   ledsweep_if.slave       wb,
   output logic [NLED-1:0] o_led,
   output logic            o_busy
`ifdef LEDSWEEP_IRQ_EN
   ,
   output logic            o_int
`endif
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [4:0]      LAST_POS = 5'(NLED - 1);
   localparam logic [NLED-1:0] LED0     = NLED'(1);

   state_t          state;
   logic [DIVW-1:0] period;
   logic [DIVW-1:0] hold;
   logic [7:0]      rem;
   logic            mode;
   logic            dir_dn;
   logic [4:0]      pos;

   logic            stall;
   logic            accept;
   logic            wr_ctrl;
   logic            wr_period;
   logic [31:0]     rd_data;

   logic [4:0]      nxt_pos;
   logic            nxt_dn;
   logic [7:0]      nxt_rem;
   logic            sweep_end;

   assign stall         = o_busy & wb.i_wb_we & ~wb.i_wb_addr;
   assign wb.o_wb_stall = stall;
   assign accept        = wb.i_wb_cyc & wb.i_wb_stb & ~stall;
   assign wr_ctrl       = accept & wb.i_wb_we & ~wb.i_wb_addr;
   assign wr_period     = accept & wb.i_wb_we & wb.i_wb_addr;

   always_comb begin
      rd_data = '0;
      if (!wb.i_wb_addr)
         rd_data = {o_busy, 14'b0, mode, rem, 3'b0, pos};
      else
         rd_data[DIVW-1:0] = period;
   end

   // Position step taken when the current hold expires. Later bounce passes
   // restart at 1 so that position 0 is never shown twice in a row.
   always_comb begin
      nxt_pos   = pos;
      nxt_dn    = dir_dn;
      nxt_rem   = rem;
      sweep_end = 1'b0;
      if (mode) begin
         if (pos == LAST_POS) begin
            if (rem == '0) begin
               sweep_end = 1'b1;
            end else begin
               nxt_rem = rem - 8'd1;
               nxt_pos = '0;
            end
         end else begin
            nxt_pos = pos + 5'd1;
         end
      end else if (!dir_dn) begin
         if (pos == LAST_POS) begin
            nxt_dn  = 1'b1;
            nxt_pos = pos - 5'd1;
         end else begin
            nxt_pos = pos + 5'd1;
         end
      end else begin
         if (pos == '0) begin
            if (rem == '0) begin
               sweep_end = 1'b1;
            end else begin
               nxt_rem = rem - 8'd1;
               nxt_dn  = 1'b0;
               nxt_pos = 5'd1;
            end
         end else begin
            nxt_pos = pos - 5'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= S_IDLE;
         period       <= DIVW'(DEF_PERIOD);
         hold         <= '0;
         rem          <= '0;
         mode         <= 1'b0;
         dir_dn       <= 1'b0;
         pos          <= '0;
         o_led        <= '0;
         o_busy       <= 1'b0;
         wb.o_wb_ack  <= 1'b0;
         wb.o_wb_data <= '0;
`ifdef LEDSWEEP_IRQ_EN
         o_int        <= 1'b0;
`endif
      end else begin
         wb.o_wb_ack <= accept;
         if (accept)
            wb.o_wb_data <= rd_data;
         if (wr_period)
            period <= wb.i_wb_data[DIVW-1:0];
`ifdef LEDSWEEP_IRQ_EN
         o_int <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (wr_ctrl) begin
                  state  <= S_RUN;
                  rem    <= wb.i_wb_data[7:0];
                  mode   <= wb.i_wb_data[8];
                  pos    <= '0;
                  dir_dn <= 1'b0;
                  hold   <= period;
                  o_led  <= LED0;
                  o_busy <= 1'b1;
               end
            end
            S_RUN: begin
               if (hold != '0) begin
                  hold <= hold - DIVW'(1);
               end else if (sweep_end) begin
                  state  <= S_IDLE;
                  pos    <= '0;
                  dir_dn <= 1'b0;
                  o_led  <= '0;
                  o_busy <= 1'b0;
`ifdef LEDSWEEP_IRQ_EN
                  o_int  <= 1'b1;
`endif
               end else begin
                  pos    <= nxt_pos;
                  dir_dn <= nxt_dn;
                  rem    <= nxt_rem;
                  hold   <= period;
                  o_led  <= LED0 << nxt_pos;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
